l2_bank_fill_check: RTL and testbench

L2_BANK_FILL_CHECK -- requirements
Module: l2_bank_fill_check

---
 rtl/l2_bank_fill_check.sv | 165 ++++++++++++++++
 tb/tb_l2_bank_fill_check.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_bank_fill_check.sv
// L2 bank fill/check sequencer: writes pattern^address across the bank, reads it
// back with a one-cycle-latency compare, and reports mismatch status.
//
// state | meaning
// IDLE  | waiting for start_i; memory interface parked
// FILL  | one write per cycle, address ascending
// READ  | one read per cycle, address ascending; compare trails by one cycle
// DRAIN | final compare of the last read, then done_o
module l2_bank_fill_check #(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_WORDS  = 8192
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [1:0]            mode_i,
    input  logic [31:0]           pattern_i,
    output logic                  mem_csn_o,
    output logic                  mem_wen_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_add_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [15:0]           err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    typedef enum logic [1:0] {IDLE, FILL, READ, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
    localparam logic [1:0] MODE_FILL  = 2'b00;
    localparam logic [1:0] MODE_CHECK = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [31:0]             pattern_q, pattern_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    cmp_valid_q, cmp_valid_d;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
    logic [15:0]             err_count_q;
    logic                    done_d, clear_d, cmp_en, mismatch, access_d;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        addr_d      = addr_q;
        cmp_valid_d = 1'b0;
        cmp_addr_d  = cmp_addr_q;
        cmp_en      = cmp_valid_q;
        done_d      = 1'b0;
        clear_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !abort_i && mode_i != MODE_RSVD) begin
                    state_d   = (mode_i == MODE_CHECK) ? READ : FILL;
                    mode_d    = mode_i;
                    pattern_d = pattern_i;
                    addr_d    = '0;
                    clear_d   = 1'b1;
                end
            end
            FILL: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    addr_d = '0;
                    if (mode_q == MODE_FILL) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            READ: begin
                // the read issued this cycle is compared next cycle unless aborted
                cmp_valid_d = !abort_i;
                cmp_addr_d  = addr_q;
                if (abort_i) begin
                    state_d = IDLE;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                if (abort_i) begin
                    cmp_en = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access_d = (state_d == FILL) || (state_d == READ);
    assign mismatch = cmp_en && (mem_rdata_i != (pattern_q ^ 32'(cmp_addr_q)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mode_q      <= MODE_FILL;
            pattern_q   <= '0;
            addr_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            mem_csn_o   <= 1'b1;
            mem_wen_o   <= 1'b1;
            mem_be_o    <= 4'h0;
            mem_add_o   <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            addr_q      <= addr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            mem_csn_o   <= !access_d;
            mem_wen_o   <= (state_d != FILL);
            mem_be_o    <= access_d ? 4'hF : 4'h0;
            mem_add_o   <= access_d ? addr_d : '0;
            mem_wdata_o <= (state_d == FILL) ? (pattern_d ^ 32'(addr_d)) : 32'h0;
            busy_o      <= (state_d != IDLE);
            done_o      <= done_d;
        end
    end

    // status only updates on start or on a mismatch, otherwise it holds
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            error_o          <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_o <= '0;
        end else if (clear_d) begin
            error_o          <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_o <= '0;
        end else if (mismatch) begin
            error_o <= 1'b1;
            if (err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
            if (!error_o) begin
                first_err_addr_o <= cmp_addr_q;
            end
        end
    end

    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_l2_bank_fill_check.sv
// Bench for l2_bank_fill_check: 8-word sweep against a 1-cycle-latency memory model,
// expected accesses queued at start and checked as the DUT issues them.
module tb_l2_bank_fill_check;

    localparam int AW = 13;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort;
    logic [1:0]    mode;
    logic [31:0]   pattern;
    logic          mem_csn_o, mem_wen_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_add_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   rdata = 32'h0;
    logic          busy_o, done_o, error_o;
    logic [15:0]   err_count_o;
    logic [AW-1:0] first_err_addr_o;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            cyc;
    } acc_t;

    acc_t        sb[$];
    acc_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          edge_n = 0;
    int          sweep_e0 = 0;
    logic [31:0] mem [0:NW-1];
    logic        corrupt [0:NW-1];

    l2_bank_fill_check #(.ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .mode_i(mode), .pattern_i(pattern),
        .mem_csn_o(mem_csn_o), .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o),
        .mem_add_o(mem_add_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(rdata),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // ideal memory, read data one cycle after the access; corrupt[] flips a bit
    always @(posedge clk) begin
        if (!mem_csn_o) begin
            if (!mem_wen_o) mem[mem_add_o[2:0]] <= mem_wdata_o;
            else rdata <= mem[mem_add_o[2:0]] ^ (corrupt[mem_add_o[2:0]] ? 32'h0000_8000 : 32'h0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!mem_csn_o) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_access got addr %0d wen %b required no access", mem_add_o, mem_wen_o);
                end else begin
                    mon_e = sb.pop_front();
                    n_cmp++;
                    if ({mem_wen_o, mem_be_o, mem_add_o} !== {mon_e.wen, 4'hF, mon_e.addr}) begin
                        n_fail++;
                        $display("FAIL access_ctrl got wen %b be %h addr %0d required wen %b be f addr %0d",
                                 mem_wen_o, mem_be_o, mem_add_o, mon_e.wen, mon_e.addr);
                    end
                    n_cmp++;
                    if ((edge_n - sweep_e0 + 1) !== mon_e.cyc) begin
                        n_fail++;
                        $display("FAIL access_cycle got %0d required %0d", edge_n - sweep_e0 + 1, mon_e.cyc);
                    end
                    if (!mon_e.wen) begin
                        n_cmp++;
                        if (mem_wdata_o !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL write_data got %h required %h", mem_wdata_o, mon_e.data);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if ({mem_wen_o, mem_be_o, mem_add_o, mem_wdata_o} !== {1'b1, 4'h0, {AW{1'b0}}, 32'h0}) begin
                    n_fail++;
                    $display("FAIL idle_bus got wen %b be %h addr %0d wdata %h required 1/0/0/0",
                             mem_wen_o, mem_be_o, mem_add_o, mem_wdata_o);
                end
            end
        end
    end

    task automatic push_writes(input logic [31:0] pat, input int first_cyc);
        for (int a = 0; a < NW; a++) sb.push_back('{1'b0, AW'(a), pat ^ 32'(a), first_cyc + a});
    endtask

    task automatic push_reads(input int first_cyc, input int n);
        for (int a = 0; a < n; a++) sb.push_back('{1'b1, AW'(a), 32'h0, first_cyc + a});
    endtask

    task automatic preload(input logic [31:0] pat);
        for (int a = 0; a < NW; a++) begin
            mem[a] = pat ^ 32'(a);
            corrupt[a] = 1'b0;
        end
    endtask

    task automatic start_sweep(input logic [1:0] m, input logic [31:0] pat);
        @(negedge clk);
        start = 1'b1; mode = m; pattern = pat;
        @(posedge clk);
        #1;
        sweep_e0 = edge_n;
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o) begin
                c = edge_n - sweep_e0 + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; pattern = 32'h0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mem_csn_o, mem_wen_o, mem_be_o, mem_add_o, mem_wdata_o} !== {1'b1, 1'b1, 4'h0, {AW{1'b0}}, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_bus got csn %b wen %b be %h addr %0d wdata %h required 1/1/0/0/0",
                     mem_csn_o, mem_wen_o, mem_be_o, mem_add_o, mem_wdata_o);
        end
        n_cmp++;
        if ({busy_o, done_o, error_o, err_count_o, first_err_addr_o} !== {3'b000, 16'h0, {AW{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_status got busy %b done %b err %b cnt %h first %0d required all zero",
                     busy_o, done_o, error_o, err_count_o, first_err_addr_o);
        end
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_busy got %b required 0", busy_o);
        end
    endtask

    task automatic test_fill();
        int c;
        push_writes(32'hA5A5_0000, 1);
        start_sweep(2'b00, 32'hA5A5_0000);
        @(negedge clk);
        n_cmp++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL fill_busy got %b required 1", busy_o); end
        wait_done(c);
        n_cmp++;
        if (c !== 9) begin n_fail++; $display("FAIL fill_done_cycle got %0d required 9", c); end
        n_cmp++;
        if ({busy_o, error_o} !== 2'b00) begin n_fail++; $display("FAIL fill_end_state got busy %b err %b required 0 0", busy_o, error_o); end
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL fill_missing_access got %0d left required 0", sb.size()); end
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL fill_done_pulse got %b required 0", done_o); end
    endtask

    task automatic test_fill_check();
        int c;
        for (int a = 0; a < NW; a++) corrupt[a] = 1'b0;
        push_writes(32'hDEAD_BEEF, 1);
        push_reads(NW + 1, NW);
        start_sweep(2'b01, 32'hDEAD_BEEF);
        wait_done(c);
        n_cmp++;
        if (c !== 2 * NW + 2) begin n_fail++; $display("FAIL fc_done_cycle got %0d required %0d", c, 2 * NW + 2); end
        n_cmp++;
        if ({error_o, err_count_o} !== {1'b0, 16'h0}) begin n_fail++; $display("FAIL fc_status got err %b cnt %h required 0 0", error_o, err_count_o); end
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL fc_missing_access got %0d left required 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_check_errors();
        int c;
        preload(32'h3C3C_1234);
        corrupt[3] = 1'b1; corrupt[5] = 1'b1;
        push_reads(1, NW);
        start_sweep(2'b10, 32'h3C3C_1234);
        wait_done(c);
        n_cmp++;
        if (c !== NW + 2) begin n_fail++; $display("FAIL chk_done_cycle got %0d required %0d", c, NW + 2); end
        n_cmp++;
        if ({error_o, err_count_o, first_err_addr_o} !== {1'b1, 16'd2, AW'(3)}) begin
            n_fail++;
            $display("FAIL chk_status got err %b cnt %0d first %0d required 1 2 3", error_o, err_count_o, first_err_addr_o);
        end
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL chk_missing_access got %0d left required 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_abort();
        int c;
        preload(32'h1357_9BDF);
        push_reads(1, 5);
        start_sweep(2'b10, 32'h1357_9BDF);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (mem_add_o !== AW'(4)) begin n_fail++; $display("FAIL abort_addr got %0d required 4", mem_add_o); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_cmp++;
        if ({mem_csn_o, busy_o, done_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_idle got csn %b busy %b done %b required 1 0 0", mem_csn_o, busy_o, done_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %b required 0", done_o); end
        end
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL abort_missing_access got %0d left required 0", sb.size()); end
        sb.delete();
        push_reads(1, NW);
        start_sweep(2'b10, 32'h1357_9BDF);
        wait_done(c);
        n_cmp++;
        if (c !== NW + 2) begin n_fail++; $display("FAIL restart_done_cycle got %0d required %0d", c, NW + 2); end
        n_cmp++;
        if ({error_o, err_count_o} !== {1'b0, 16'h0}) begin n_fail++; $display("FAIL restart_status got err %b cnt %h required 0 0", error_o, err_count_o); end
        sb.delete();
    endtask

    task automatic test_saturate();
        int c;
        preload(32'h0F0F_F0F0);
        corrupt[5] = 1'b1; corrupt[6] = 1'b1; corrupt[7] = 1'b1;
        push_reads(1, NW);
        start_sweep(2'b10, 32'h0F0F_F0F0);
        @(negedge clk);
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.err_count_q;
        wait_done(c);
        n_cmp++;
        if (c !== NW + 2) begin n_fail++; $display("FAIL sat_done_cycle got %0d required %0d", c, NW + 2); end
        n_cmp++;
        if ({error_o, err_count_o, first_err_addr_o} !== {1'b1, 16'hFFFF, AW'(5)}) begin
            n_fail++;
            $display("FAIL sat_status got err %b cnt %h first %0d required 1 ffff 5", error_o, err_count_o, first_err_addr_o);
        end
        sb.delete();
    endtask

    task automatic test_reset_busy_reserved();
        int c;
        sb.push_back('{1'b0, AW'(0), 32'h7777_0000, 1});
        sb.push_back('{1'b0, AW'(1), 32'h7777_0001, 2});
        sb.push_back('{1'b0, AW'(2), 32'h7777_0002, 3});
        start_sweep(2'b00, 32'h7777_0000);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_csn_o, mem_wen_o, mem_be_o, busy_o, done_o, error_o, err_count_o} !== {1'b1, 1'b1, 4'h0, 3'b000, 16'h0}) begin
            n_fail++;
            $display("FAIL midreset_values got csn %b wen %b be %h busy %b done %b err %b cnt %h required 1 1 0 0 0 0 0",
                     mem_csn_o, mem_wen_o, mem_be_o, busy_o, done_o, error_o, err_count_o);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL midreset_idle got busy %b done %b required 0 0", busy_o, done_o); end
        end
        sb.delete();
        push_writes(32'h2468_ACE0, 1);
        start_sweep(2'b00, 32'h2468_ACE0);
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 2'b10; pattern = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        n_cmp++;
        if (c !== NW + 1) begin n_fail++; $display("FAIL busy_start_done_cycle got %0d required %0d", c, NW + 1); end
        n_cmp++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL busy_start_missing_access got %0d left required 0", sb.size()); end
        sb.delete();
        start_sweep(2'b11, 32'h1111_2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy_o, done_o, mem_csn_o} !== 3'b001) begin
                n_fail++;
                $display("FAIL reserved_mode got busy %b done %b csn %b required 0 0 1", busy_o, done_o, mem_csn_o);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < NW; a++) begin
            mem[a] = 32'h0;
            corrupt[a] = 1'b0;
        end
        test_reset();
        test_fill();
        test_fill_check();
        test_check_errors();
        test_abort();
        test_saturate();
        test_reset_busy_reserved();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
